// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller and the D/E/M decoders.
//   T_W             width of the Tuse/Tnew fields
//   TUSE_NONE       Tuse code meaning "operand not read"
//   fwd_sel_e       D-stage forwarding source select
//   MULT_CYC_DEF    default mult/multu busy cycles after leaving E
//   DIV_CYC_DEF     default div/divu busy cycles after leaving E
//   MD_CNT_W        width of the mult/div busy down-counter
package hazard_pkg;

    localparam int T_W = 2;
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int MD_CNT_W     = 4;

    // True when a later stage will write the register a D-stage operand names.
    // Register 0 is hard-wired, so it never matches.
    function automatic logic reg_match(input logic we, input logic [4:0] dst,
                                       input logic [4:0] src);
        return we && (dst == src) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Busy window of the multi-cycle mult/div unit.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_md_start       mult/div instruction is in E (one-cycle pulse)
//   i_md_div         with i_md_start: 1 = div, 0 = mult
//   o_md_busy        unit occupied (includes the start cycle itself)
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_md_start,
    input  logic i_md_div,
    output logic o_md_busy
);

    logic [MD_CNT_W-1:0] r_md_cnt;
    logic                w_cnt_nz;

    assign w_cnt_nz = (r_md_cnt != '0);

    // A new start always reloads, so back-to-back ops track the latest one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_md_cnt <= '0;
        end else if (i_md_start) begin
            r_md_cnt <= i_md_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end else if (w_cnt_nz) begin
            r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
        end
    end

    assign o_md_busy = i_md_start || w_cnt_nz;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall / bubble / forwarding controller for the 5-stage core.
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_d_rs, i_d_rt, i_d_tuse_rs/rt       D-stage operands and their Tuse
//   i_d_is_md                            D instr touches the mult/div unit
//   i_e_dst, i_e_we, i_e_tnew            E-stage writeback info
//   i_e_md_start, i_e_md_div             mult/div launch from E
//   i_m_dst, i_m_we, i_m_tnew            M-stage writeback info
//   o_stall, o_e_flush                   hold F/D, bubble into E
//   o_fwd_rs, o_fwd_rt                   D-stage forward selects
//   o_md_busy                            mult/div unit occupied
//   o_stall_cnt                          stall cycles since reset (wraps)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_d_rs,
    input  logic [4:0]       i_d_rt,
    input  logic [T_W-1:0]   i_d_tuse_rs,
    input  logic [T_W-1:0]   i_d_tuse_rt,
    input  logic             i_d_is_md,
    input  logic [4:0]       i_e_dst,
    input  logic             i_e_we,
    input  logic [T_W-1:0]   i_e_tnew,
    input  logic             i_e_md_start,
    input  logic             i_e_md_div,
    input  logic [4:0]       i_m_dst,
    input  logic             i_m_we,
    input  logic [T_W-1:0]   i_m_tnew,
    output logic             o_stall,
    output logic             o_e_flush,
    output logic [1:0]       o_fwd_rs,
    output logic [1:0]       o_fwd_rt,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic w_e_rs, w_m_rs, w_e_rt, w_m_rt;
    logic w_stall_rs, w_stall_rt, w_stall_md, w_stall;
    logic w_md_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    md_busy_tracker #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_md_start (i_e_md_start),
        .i_md_div   (i_e_md_div),
        .o_md_busy  (w_md_busy)
    );

    assign w_e_rs = reg_match(i_e_we, i_e_dst, i_d_rs);
    assign w_m_rs = reg_match(i_m_we, i_m_dst, i_d_rs);
    assign w_e_rt = reg_match(i_e_we, i_e_dst, i_d_rt);
    assign w_m_rt = reg_match(i_m_we, i_m_dst, i_d_rt);

    // Stall only when the producer's result arrives later than D needs it.
    assign w_stall_rs = (i_d_tuse_rs != TUSE_NONE) &&
                        ((w_e_rs && (i_e_tnew > i_d_tuse_rs)) ||
                         (w_m_rs && (i_m_tnew > i_d_tuse_rs)));
    assign w_stall_rt = (i_d_tuse_rt != TUSE_NONE) &&
                        ((w_e_rt && (i_e_tnew > i_d_tuse_rt)) ||
                         (w_m_rt && (i_m_tnew > i_d_tuse_rt)));
    assign w_stall_md = i_d_is_md && w_md_busy;
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    // E is the younger producer, so it wins over M.
    always_comb begin
        o_fwd_rs = FWD_RF;
        o_fwd_rt = FWD_RF;
        if (w_e_rs && (i_e_tnew == '0))      o_fwd_rs = FWD_E;
        else if (w_m_rs && (i_m_tnew == '0)) o_fwd_rs = FWD_M;
        if (w_e_rt && (i_e_tnew == '0))      o_fwd_rt = FWD_E;
        else if (w_m_rt && (i_m_tnew == '0)) o_fwd_rt = FWD_M;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall     = w_stall;
    assign o_e_flush   = w_stall;
    assign o_md_busy   = w_md_busy;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] d_rs, d_rt, e_dst, m_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_we, e_md_start, e_md_div, m_we;

    logic        stall_a, flush_a, busy_a, stall_b, flush_b, busy_b;
    logic [1:0]  fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_tuse_rs(d_tuse_rs), .i_d_tuse_rt(d_tuse_rt),
        .i_d_is_md(d_is_md), .i_e_dst(e_dst), .i_e_we(e_we), .i_e_tnew(e_tnew),
        .i_e_md_start(e_md_start), .i_e_md_div(e_md_div),
        .i_m_dst(m_dst), .i_m_we(m_we), .i_m_tnew(m_tnew),
        .o_stall(stall_a), .o_e_flush(flush_a), .o_fwd_rs(fwd_rs_a), .o_fwd_rt(fwd_rt_a),
        .o_md_busy(busy_a), .o_stall_cnt(cnt_a)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_d_rs(d_rs), .i_d_rt(d_rt), .i_d_tuse_rs(d_tuse_rs), .i_d_tuse_rt(d_tuse_rt),
        .i_d_is_md(d_is_md), .i_e_dst(e_dst), .i_e_we(e_we), .i_e_tnew(e_tnew),
        .i_e_md_start(e_md_start), .i_e_md_div(e_md_div),
        .i_m_dst(m_dst), .i_m_we(m_we), .i_m_tnew(m_tnew),
        .o_stall(stall_b), .o_e_flush(flush_b), .o_fwd_rs(fwd_rs_b), .o_fwd_rt(fwd_rt_b),
        .o_md_busy(busy_b), .o_stall_cnt(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: busy window as an absolute cycle deadline, stall count as a plain integer.
    int     cyc_m    = 0;
    int     deadline = -1;
    longint cnt_m    = 0;

    function automatic bit m_busy();
        return e_md_start || (cyc_m <= deadline);
    endfunction

    function automatic bit m_haz(input logic [4:0] src, input logic [1:0] tuse);
        if (src == 5'd0 || tuse == 2'd3) return 1'b0;
        return (e_we && e_dst == src && e_tnew > tuse) ||
               (m_we && m_dst == src && m_tnew > tuse);
    endfunction

    function automatic bit m_stall();
        return m_haz(d_rs, d_tuse_rs) || m_haz(d_rt, d_tuse_rt) || (d_is_md && m_busy());
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src != 5'd0 && e_we && e_dst == src && e_tnew == 2'd0) return 2'd1;
        if (src != 5'd0 && m_we && m_dst == src && m_tnew == 2'd0) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deadline = -1;
            cnt_m    = 0;
        end else begin
            if (m_stall()) cnt_m++;
            cyc_m++;
            if (e_md_start) deadline = cyc_m + (e_md_div ? 10 : 5) - 1;
        end
    end

    always @(negedge clk) begin
        chk("stall",     {63'd0, stall_a},  {63'd0, m_stall()});
        chk("e_flush",   {63'd0, flush_a},  {63'd0, m_stall()});
        chk("fwd_rs",    {62'd0, fwd_rs_a}, {62'd0, m_fwd(d_rs)});
        chk("fwd_rt",    {62'd0, fwd_rt_a}, {62'd0, m_fwd(d_rt)});
        chk("md_busy",   {63'd0, busy_a},   {63'd0, m_busy()});
        chk("stall_cnt", {32'd0, cnt_a},    64'(cnt_m % 64'h1_0000_0000));
        chk("stall4",    {63'd0, stall_b},  {63'd0, m_stall()});
        chk("stall_cnt4",{60'd0, cnt_b},    64'(cnt_m % 16));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 0;
        e_dst = 0; e_we = 0; e_tnew = 0; e_md_start = 0; e_md_div = 0;
        m_dst = 0; m_we = 0; m_tnew = 0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        #12;
        chk("rst_cnt",  {32'd0, cnt_a}, 64'd0);
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        #5 rst_n = 1'b1;

        // Load-use then forwarding from M.
        nxt();
        e_dst = 5; e_we = 1; e_tnew = 2; d_rs = 5; d_tuse_rs = 1;
        @(negedge clk);
        chk("lu_stall", {63'd0, stall_a}, 64'd1);
        chk("lu_flush", {63'd0, flush_a}, 64'd1);
        chk("lu_fwd",   {62'd0, fwd_rs_a}, 64'd0);
        nxt();
        e_we = 0; e_dst = 0; m_dst = 5; m_we = 1; m_tnew = 1;
        @(negedge clk);
        chk("lu2_stall", {63'd0, stall_a}, 64'd0);
        chk("lu2_fwd",   {62'd0, fwd_rs_a}, 64'd0);
        nxt();
        m_tnew = 0;
        @(negedge clk);
        chk("lu3_fwd", {62'd0, fwd_rs_a}, 64'd2);
        chk("lu_cnt",  {32'd0, cnt_a}, 64'd1);

        // E over M priority, then register 0.
        nxt();
        clr();
        e_dst = 8; m_dst = 8; e_we = 1; m_we = 1; d_rt = 8; d_tuse_rt = 0;
        @(negedge clk);
        chk("pri_stall", {63'd0, stall_a}, 64'd0);
        chk("pri_fwd",   {62'd0, fwd_rt_a}, 64'd1);
        nxt();
        e_dst = 0; d_rt = 0;
        @(negedge clk);
        chk("r0_fwd",   {62'd0, fwd_rt_a}, 64'd0);
        chk("r0_stall", {63'd0, stall_a}, 64'd0);
        nxt();
        clr(); d_rt = 0; e_dst = 0; m_dst = 0; e_tnew = 3; e_we = 1; d_tuse_rt = 0;
        @(negedge clk);
        chk("r0_nostall", {63'd0, stall_a}, 64'd0);

        // Div window: 11 stall cycles.
        nxt();
        clr();
        pulse_reset();
        nxt();
        e_md_start = 1; e_md_div = 1; d_is_md = 1;
        @(negedge clk);
        chk("div_s0", {63'd0, stall_a}, 64'd1);
        for (int i = 1; i <= 10; i++) begin
            nxt();
            e_md_start = 0; e_md_div = 0;
            @(negedge clk);
            chk("div_win", {63'd0, stall_a}, 64'd1);
        end
        nxt();
        @(negedge clk);
        chk("div_end_stall", {63'd0, stall_a}, 64'd0);
        chk("div_end_busy",  {63'd0, busy_a}, 64'd0);
        chk("div_cnt",       {32'd0, cnt_a}, 64'd11);

        // Mult then div restart two cycles later.
        nxt();
        clr();
        pulse_reset();
        nxt();
        e_md_start = 1; e_md_div = 0;
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) begin
                nxt();
                e_md_start = (i == 2); e_md_div = (i == 2);
            end
            @(negedge clk);
            chk("restart_busy", {63'd0, busy_a}, (i <= 12) ? 64'd1 : 64'd0);
        end

        // Async reset in the middle of a divide.
        nxt();
        clr();
        pulse_reset();
        nxt();
        e_md_start = 1; e_md_div = 1; d_is_md = 1;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            e_md_start = 0; e_md_div = 0;
        end
        chk("pre_rst_cnt", {32'd0, cnt_a}, 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy_a}, 64'd0);
        chk("arst_cnt",  {32'd0, cnt_a}, 64'd0);
        chk("arst_stall",{63'd0, stall_a}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nxt();
        @(negedge clk);
        chk("post_rst_stall", {63'd0, stall_a}, 64'd0);
        chk("post_rst_busy",  {63'd0, busy_a}, 64'd0);

        // 4-bit counter wrap under a held load-use stall.
        nxt();
        clr();
        pulse_reset();
        nxt();
        e_dst = 3; e_we = 1; e_tnew = 2; d_rs = 3; d_tuse_rs = 0;
        for (int i = 0; i <= 17; i++) begin
            if (i > 0) nxt();
            if (i == 17) clr();
            @(negedge clk);
            chk("wrap4", {60'd0, cnt_b}, 64'(i % 16));
        end
        chk("wrap32", {32'd0, cnt_a}, 64'd17);

        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
